// File: rtl/sm_hex_pkg.sv
// Shared definitions for the hex display controller: scan state encoding,
// blank segment code and the hex-to-seven-segment table.
package sm_hex_pkg;

  typedef enum logic [1:0] {
    SCAN_OFF   = 2'd0,
    SCAN_GUARD = 2'd1,
    SCAN_SHOW  = 2'd2
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; entry 0 sits in the least significant slice.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/sm_hex_seg7.sv
// Combinational 4-bit to active-low seven-segment decoder with blank override.
module sm_hex_seg7
  import sm_hex_pkg::*;
(
  input  logic [3:0] hex,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = blank ? SEG_BLANK : SEG_TABLE[hex];
  end

endmodule

// File: rtl/sm_hex_scan.sv
// N-digit hex display: captured value, leading-zero blanking, registered
// static per-digit segments and a guarded multiplexed scan with anodes.
module sm_hex_scan
  import sm_hex_pkg::*;
#(
  parameter int DIGITS   = 6,
  parameter int SCAN_DIV = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  data_valid,
  input  logic                  hold,
  input  logic                  blank_lz,
  input  logic                  scan_en,
  output logic [7*DIGITS-1:0]   seg_static,
  output logic [6:0]            seg_mux,
  output logic [DIGITS-1:0]     an,
  output scan_state_e           dbg_state
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] data_q, data_d;
  logic [7*DIGITS-1:0] seg_static_q, seg_static_d;
  scan_state_e         state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [SCAN_DIV-1:0] presc_q, presc_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_mux_q, seg_mux_d;

  logic [DIGITS-1:0]   blank_mask;
  logic                zero_run;
  logic [3:0]          mux_hex;
  logic                mux_blank;
  logic [6:0]          mux_seg;

  // data_valid is a one-cycle capture strobe with no back-pressure; hold
  // overrides it so the displayed value stays frozen.
  always_comb begin
    data_d = (data_valid && !hold) ? data : data_q;
  end

  // Blank every digit above the most significant nonzero one; digit 0 never.
  always_comb begin
    zero_run   = blank_lz;
    blank_mask = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run      = zero_run && (data_q[4*i +: 4] == 4'h0);
      blank_mask[i] = zero_run;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_static
    sm_hex_seg7 u_seg7 (
      .hex   (data_q[4*g +: 4]),
      .blank (blank_mask[g]),
      .seg   (seg_static_d[7*g +: 7])
    );
  end

  // Scan FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q       <= '0;
      seg_static_q <= {DIGITS{SEG_BLANK}};
      state_q      <= SCAN_OFF;
      idx_q        <= '0;
      presc_q      <= '0;
      an_q         <= '1;
      seg_mux_q    <= SEG_BLANK;
    end else begin
      data_q       <= data_d;
      seg_static_q <= seg_static_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      presc_q      <= presc_d;
      an_q         <= an_d;
      seg_mux_q    <= seg_mux_d;
    end
  end

  // Scan FSM: next state, digit index and prescaler.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    presc_d = presc_q;
    if (!scan_en) begin
      state_d = SCAN_OFF;
      idx_d   = '0;
      presc_d = '0;
    end else begin
      case (state_q)
        SCAN_OFF: begin
          state_d = SCAN_GUARD;
          idx_d   = '0;
          presc_d = '0;
        end
        SCAN_GUARD: begin
          state_d = SCAN_SHOW;
          presc_d = '0;
        end
        SCAN_SHOW: begin
          if (presc_q == '1) begin
            state_d = SCAN_GUARD;
            presc_d = '0;
            idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        default: begin
          state_d = SCAN_OFF;
          idx_d   = '0;
          presc_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    mux_hex   = '0;
    mux_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) == idx_d) begin
        mux_hex   = data_q[4*i +: 4];
        mux_blank = blank_mask[i];
      end
    end
  end

  sm_hex_seg7 u_mux_seg7 (
    .hex   (mux_hex),
    .blank (mux_blank),
    .seg   (mux_seg)
  );

  // Scan FSM: outputs derived from the next state so an and seg_mux
  // register together with the state they describe.
  always_comb begin
    an_d      = '1;
    seg_mux_d = SEG_BLANK;
    if (state_d == SCAN_SHOW) begin
      an_d[idx_d] = 1'b0;
      seg_mux_d   = mux_seg;
    end
  end

  assign seg_static = seg_static_q;
  assign seg_mux    = seg_mux_q;
  assign an         = an_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sm_hex_scan.sv
// Directed bench for sm_hex_scan with DIGITS=6, SCAN_DIV=2.
module tb_sm_hex_scan;
  import sm_hex_pkg::*;

  localparam int DIGITS   = 6;
  localparam int SCAN_DIV = 2;

  logic                clk;
  logic                rst;
  logic [4*DIGITS-1:0] data;
  logic                data_valid;
  logic                hold;
  logic                blank_lz;
  logic                scan_en;
  logic [7*DIGITS-1:0] seg_static;
  logic [6:0]          seg_mux;
  logic [DIGITS-1:0]   an;
  scan_state_e         dbg_state;

  int vec_cnt;
  int err_cnt;

  logic [5:0] an_exp_q[$];
  logic [6:0] exp_q[$];

  localparam logic [7*DIGITS-1:0] ALL_BLANK = {6{7'h7F}};
  localparam logic [7*DIGITS-1:0] ZERO_LZ   = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [7*DIGITS-1:0] A3F0_LZ   = {7'h7F, 7'h7F, 7'h08, 7'h30, 7'h0E, 7'h40};
  localparam logic [7*DIGITS-1:0] A3F0_NOLZ = {7'h40, 7'h40, 7'h08, 7'h30, 7'h0E, 7'h40};
  localparam logic [7*DIGITS-1:0] V123456   = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};

  logic [6:0] dig_seg [DIGITS];

  sm_hex_scan #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .data_valid (data_valid),
    .hold       (hold),
    .blank_lz   (blank_lz),
    .scan_en    (scan_en),
    .seg_static (seg_static),
    .seg_mux    (seg_mux),
    .an         (an),
    .dbg_state  (dbg_state)
  );

  // Clock / reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    vec_cnt    = 0;
    err_cnt    = 0;
    rst        = 1'b1;
    data       = '0;
    data_valid = 1'b0;
    hold       = 1'b0;
    blank_lz   = 1'b1;
    scan_en    = 1'b0;
    dig_seg    = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};

    // Reset state and release.
    tick(1);
    check_vec("rst_static", 64'(seg_static), 64'(ALL_BLANK));
    check_vec("rst_an", 64'(an), 64'(6'h3F));
    check_vec("rst_mux", 64'(seg_mux), 64'(7'h7F));
    check_vec("rst_state", 64'(dbg_state), 64'(SCAN_OFF));
    rst = 1'b0;
    tick(1);
    check_vec("rel_static", 64'(seg_static), 64'(ZERO_LZ));

    // Capture latency and blanking.
    data       = 24'h00A3F0;
    data_valid = 1'b1;
    tick(1);
    data_valid = 1'b0;
    check_vec("cap_lat1", 64'(seg_static), 64'(ZERO_LZ));
    tick(1);
    check_vec("cap_lat2", 64'(seg_static), 64'(A3F0_LZ));
    blank_lz = 1'b0;
    tick(1);
    check_vec("nolz", 64'(seg_static), 64'(A3F0_NOLZ));
    blank_lz = 1'b1;
    tick(1);
    check_vec("lz_again", 64'(seg_static), 64'(A3F0_LZ));

    // Hold wins over data_valid.
    hold       = 1'b1;
    data_valid = 1'b1;
    data       = 24'h123456;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check_vec("hold", 64'(seg_static), 64'(A3F0_LZ));
    end
    hold = 1'b0;
    tick(1);
    data_valid = 1'b0;
    tick(1);
    check_vec("unhold", 64'(seg_static), 64'(V123456));

    // Scan from OFF: guard, then four lit cycles plus one guard per digit.
    scan_en = 1'b1;
    tick(1);
    check_vec("scan_guard0", 64'(an), 64'(6'h3F));
    check_vec("scan_state_g", 64'(dbg_state), 64'(SCAN_GUARD));
    for (int d = 0; d < DIGITS; d++) begin
      for (int c = 0; c < 4; c++) begin
        an_exp_q.push_back(~(6'h01 << d));
        exp_q.push_back(dig_seg[d]);
      end
      an_exp_q.push_back(6'h3F);
      exp_q.push_back(7'h7F);
    end
    an_exp_q.push_back(6'h3E);
    exp_q.push_back(dig_seg[0]);
    while (an_exp_q.size() > 0) begin
      tick(1);
      check_vec("scan_an", 64'(an), 64'(an_exp_q.pop_front()));
      check_vec("scan_mux", 64'(seg_mux), 64'(exp_q.pop_front()));
    end

    // Now on the first lit cycle of digit 0; advance to first cycle of digit 3.
    tick(15);
    check_vec("idx3_an", 64'(an), 64'(6'h37));
    check_vec("idx3_mux", 64'(seg_mux), 64'(7'h30));
    scan_en = 1'b0;
    tick(1);
    check_vec("off_an", 64'(an), 64'(6'h3F));
    check_vec("off_mux", 64'(seg_mux), 64'(7'h7F));
    check_vec("off_state", 64'(dbg_state), 64'(SCAN_OFF));
    scan_en = 1'b1;
    tick(1);
    check_vec("reen_guard", 64'(an), 64'(6'h3F));
    tick(1);
    check_vec("reen_an", 64'(an), 64'(6'h3E));
    check_vec("reen_mux", 64'(seg_mux), 64'(7'h02));

    // Advance to the first lit cycle of digit 4, then reset mid-scan.
    tick(20);
    check_vec("idx4_an", 64'(an), 64'(6'h2F));
    check_vec("idx4_mux", 64'(seg_mux), 64'(7'h24));
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_vec("mid_rst_static", 64'(seg_static), 64'(ALL_BLANK));
    check_vec("mid_rst_an", 64'(an), 64'(6'h3F));
    check_vec("mid_rst_mux", 64'(seg_mux), 64'(7'h7F));
    check_vec("mid_rst_state", 64'(dbg_state), 64'(SCAN_OFF));
    tick(1);
    check_vec("post_rst_static", 64'(seg_static), 64'(ZERO_LZ));
    check_vec("post_rst_state", 64'(dbg_state), 64'(SCAN_GUARD));
    tick(1);
    check_vec("post_rst_an", 64'(an), 64'(6'h3E));
    check_vec("post_rst_mux", 64'(seg_mux), 64'(7'h40));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/sm_hex_scan.md
# sm_hex_scan

Parametrised N-digit hexadecimal display controller for the board-level debug readout of the schoolMIPS core. It registers a 4·DIGITS-bit value, optionally freezes it, applies leading-zero blanking, and drives either per-digit static seven-segment outputs, as on the DE0-CV, or a single multiplexed segment bus with scanned anodes for boards with shared segment lines. It sits in the board wrapper between `sm_top`'s `regData` output and the HEX/GPIO pins, and replaces per-digit instances of the plain decoder.

## Interface
- `DIGITS`, default 6: number of hex digits; legal range 1..8.
- `SCAN_DIV`, default 16: each multiplexed digit is lit for 2^SCAN_DIV cycles; legal range 1..24.
- `clk` input, 1 bit: the single clock. One clock domain.
- `rst` input, 1 bit: synchronous, active-high reset.
- `data` input, 4·DIGITS bits: value to display. Digit i is `data[4i+3:4i]`.
- `data_valid` input, 1 bit: capture strobe for `data`.
- `hold` input, 1 bit: while 1, `data_valid` is ignored and the display is frozen.
- `blank_lz` input, 1 bit: enables leading-zero blanking.
- `scan_en` input, 1 bit: 1 runs the multiplexed scan; 0 turns the scan off.
- `seg_static` output, 7·DIGITS bits: static segments for all digits. Digit i is `seg_static[7i+6:7i]`.
- `seg_mux` output, 7 bits: multiplexed segment bus.
- `an` output, DIGITS bits: active-low digit enables for the multiplexed bus.

## Operation
- All segment outputs are active-low with bit order {g,f,e,d,c,b,a}.
  - Encodings: 0=7'h40, 3=7'h30, A=7'h08, F=7'h0E.
  - Blank = 7'h7F.
- Capture: `data_q <= data` when `data_valid && !hold`. If `hold` and `data_valid` are high in the same cycle, `hold` wins.
- Leading-zero blanking:
  - With `blank_lz`=1, every digit above the most significant nonzero digit of `data_q` is blank.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
  - With `blank_lz`=0, no digit is blanked.
  - `blank_lz` is evaluated combinationally into the output registers.
- Static path: `seg_static` is registered and updated every cycle from `data_q` and `blank_lz`.
- Scan FSM states are OFF, GUARD and SHOW:
  - OFF: `an`=all 1, `seg_mux`=7'h7F, `idx`=0, prescaler=0. Goes to GUARD when `scan_en`=1.
  - GUARD: lasts one cycle and suppresses ghosting. `an`=all 1, prescaler cleared. Goes to SHOW.
  - SHOW: `an` has only bit `idx` low; `seg_mux` is the registered code of digit `idx`, blanking included. The prescaler increments each cycle.
  - When the prescaler is all ones (the tick), SHOW goes to GUARD and `idx` advances. The advance wraps DIGITS-1 to 0; non-power-of-two DIGITS is legal.
  - `scan_en`=0 in any state goes to OFF on the next cycle. Re-enabling always restarts at digit 0.
- Data changes while scanning take effect on the current digit within 2 cycles; the scan is not restarted.

## Timing
- Reset values:
  - `data_q`=0, state=OFF, `idx`=0, prescaler=0.
  - `seg_static`=all 7'h7F, `seg_mux`=7'h7F, `an`=all 1.
- Reset mid-operation: all outputs return to their reset values on the cycle after `rst` is sampled high.
- Capture to static-output latency is 2 cycles. `data_valid` is sampled at edge N, `data_q` is valid after N, and `seg_static` reflects it after edge N+1.
- After reset is released, `seg_static` reflects `data_q`=0 one cycle later.
- Scan period is DIGITS·(2^SCAN_DIV + 1) cycles: each digit is lit for 2^SCAN_DIV cycles plus one GUARD cycle.
- OFF to first lit digit takes 2 cycles: one into GUARD, then one into SHOW with `idx`=0.
- `an` and `seg_mux` are registered and change together, so there is no glitch between them.

## Structure
- Package `sm_hex_pkg` holds:
  - the scan state encoding (OFF, GUARD, SHOW);
  - the `SEG_BLANK` constant 7'h7F;
  - the 16-entry hex-to-segment constant table.
- One sub-module, `sm_hex_seg7`: a pure combinational 4-bit-to-7-segment decoder with a blank input. It is instantiated DIGITS times for the static path and once for the mux path.
- Leading-zero mask generation and the scan FSM live in the top of `sm_hex_scan`.

## Test plan
Parameters for all tests: DIGITS=6, SCAN_DIV=2.
- Reset release with `data`=0 and `blank_lz`=1:
  - Reset cycle: all `seg_static`=7'h7F, `an`=6'h3F.
  - One cycle later: digit 0 is 7'h40 and digits 1..5 are 7'h7F.
- `data`=24'h00A3F0 with a 1-cycle `data_valid` and `blank_lz`=1:
  - 2 cycles later, digits 0..3 are 40, 0E, 30, 08 and digits 4..5 are 7F.
  - Setting `blank_lz`=0 makes digits 4..5 7'h40 on the next cycle.
- `hold`=1 with `data_valid`=1 and `data`=24'h123456: `seg_static` is unchanged indefinitely. Releasing `hold` and pulsing `data_valid` shows 1..6 after 2 cycles.
- `scan_en` set from OFF:
  - GUARD cycle with `an`=6'h3F.
  - Then `an`=6'h3E for 4 cycles, a GUARD cycle, then 6'h3D, and so on through 6'h1F.
  - Then a wrap back to 6'h3E; the full period is 30 cycles.
- `scan_en` dropped while `idx`=3: the next cycle shows `an`=6'h3F and `seg_mux`=7'h7F. Re-asserting gives GUARD then `an`=6'h3E.
- `rst` pulsed in SHOW with `idx`=4 and `data_q`≠0: the next cycle shows all reset values and `data_q`=0, and the state is OFF with `scan_en` still high.
